// File: rtl/mem_read_capture_pkg.sv
// Shared types for the read-capture engine: FSM state encoding.
package mem_read_capture_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        WAIT_LOW = 2'd2,
        HOLD     = 2'd3
    } state_t;

endpackage

// File: rtl/mem_read_capture_if.sv
// Request/responder/result signal bundle for mem_read_capture.
// master: the side that requests reads and drives responder data.
// slave:  the capture engine itself.
interface mem_read_capture_if #(
    parameter int DATA_W  = 8,
    parameter int BURST_W = 4
);
    logic               mem_read;
    logic [BURST_W-1:0] burst_len;
    logic [DATA_W-1:0]  data_bus;
    logic               data_ready;
    logic [DATA_W-1:0]  data;
    logic               data_valid;
    logic [BURST_W-1:0] beat_cnt;
    logic               busy;
    logic               done;
    logic               timeout_err;

    modport master (
        output mem_read, burst_len, data_bus, data_ready,
        input  data, data_valid, beat_cnt, busy, done, timeout_err
    );

    modport slave (
        input  mem_read, burst_len, data_bus, data_ready,
        output data, data_valid, beat_cnt, busy, done, timeout_err
    );
endinterface

// File: rtl/mem_read_capture_rd_timeout_cnt.sv
// Per-beat wait counter. Counts up while enabled; expired_o flags the
// last allowed wait cycle (count == TIMEOUT-1). clear_i wins over enable_i.
module rd_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_read_capture.sv
// Read-capture engine: takes a level read request, captures one word per
// data_ready assertion up to the latched burst length, and reports done,
// abort (silent return to IDLE) or per-beat timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction; waiting for mem_read
// WAIT_RDY | waiting for data_ready high; timeout counter running
// WAIT_LOW | beat captured; waiting for data_ready to drop
// HOLD     | finished or timed out; waiting for mem_read to drop
module mem_read_capture
    import mem_read_capture_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BURST_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_read_capture_if.slave bus
);
    state_t             state_q, state_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic               data_valid_q, data_valid_d;
    logic               done_q, done_d;
    logic               timeout_err_q, timeout_err_d;

    logic               tmo_clear;
    logic               tmo_enable;
    logic               tmo_expired;
    logic [BURST_W-1:0] beat_next;

    assign beat_next = beat_cnt_q + BURST_W'(1);

    rd_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_enable),
        .expired_o (tmo_expired)
    );

    // Next-state and output decode; the counter is held cleared outside
    // WAIT_RDY so every entry to WAIT_RDY starts from zero.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        data_d        = data_q;
        beat_cnt_d    = beat_cnt_q;
        data_valid_d  = 1'b0;
        done_d        = 1'b0;
        timeout_err_d = 1'b0;
        tmo_clear     = 1'b1;
        tmo_enable    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_read) begin
                    len_d      = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
                    data_d     = '0;
                    beat_cnt_d = '0;
                    state_d    = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                tmo_clear  = 1'b0;
                tmo_enable = 1'b1;
                if (!bus.mem_read) begin
                    state_d = IDLE;
                end else if (bus.data_ready) begin
                    data_d       = bus.data_bus;
                    data_valid_d = 1'b1;
                    beat_cnt_d   = beat_next;
                    tmo_clear    = 1'b1;
                    if (beat_next == len_q) begin
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT_LOW;
                    end
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            WAIT_LOW: begin
                if (!bus.mem_read) begin
                    state_d = IDLE;
                end else if (!bus.data_ready) begin
                    state_d = WAIT_RDY;
                end
            end
            HOLD: begin
                if (!bus.mem_read) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            data_q        <= '0;
            beat_cnt_q    <= '0;
            data_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            data_q        <= data_d;
            beat_cnt_q    <= beat_cnt_d;
            data_valid_q  <= data_valid_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.beat_cnt    = beat_cnt_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_read_capture.sv
// Bench for mem_read_capture: scoreboard of expected captures plus
// per-scenario timing checks.
module tb_mem_read_capture;

    localparam int DATA_W  = 8;
    localparam int BURST_W = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [DATA_W-1:0]  data;
        logic [BURST_W-1:0] beat;
        logic               done;
    } sb_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    sb_t  sb_q[$];
    sb_t  mon_e;

    mem_read_capture_if #(.DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

    mem_read_capture #(
        .DATA_W  (DATA_W),
        .BURST_W (BURST_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every data_valid pulse must match the next expected capture.
    always @(posedge clk) begin
        #1;
        if (bus.data_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: data_valid with data=%h beat=%0d, required no capture",
                         bus.data, bus.beat_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                if ({bus.data, bus.beat_cnt, bus.done} !== {mon_e.data, mon_e.beat, mon_e.done}) begin
                    n_errors++;
                    $display("FAIL sb_capture: got data=%h beat=%0d done=%b, required data=%h beat=%0d done=%b",
                             bus.data, bus.beat_cnt, bus.done, mon_e.data, mon_e.beat, mon_e.done);
                end
            end
        end
    end

    task automatic start_req(input logic [BURST_W-1:0] len);
        @(negedge clk);
        bus.burst_len = len;
        bus.mem_read  = 1'b1;
    endtask

    task automatic end_req();
        @(negedge clk);
        bus.mem_read = 1'b0;
        @(posedge clk);
    endtask

    // One-cycle ready pulse; expected capture queued as the strobe is driven.
    task automatic pulse_ready(input logic [DATA_W-1:0] w, input logic [BURST_W-1:0] beat,
                               input logic last);
        sb_t e;
        @(negedge clk);
        e.data = w; e.beat = beat; e.done = last;
        sb_q.push_back(e);
        bus.data_bus   = w;
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.data !== '0) begin n_errors++; $display("FAIL reset_data: got %h, required 00", bus.data); end
        n_checks++;
        if (bus.data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, required 0", bus.data_valid); end
        n_checks++;
        if (bus.beat_cnt !== '0) begin n_errors++; $display("FAIL reset_beat: got %0d, required 0", bus.beat_cnt); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        n_checks++;
        if ({bus.done, bus.timeout_err} !== 2'b00) begin
            n_errors++; $display("FAIL reset_flags: got done/tmo=%b%b, required 00", bus.done, bus.timeout_err);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        sb_t e;
        int  extra_valid = 0;
        int  busy_low    = 0;
        @(negedge clk);
        bus.burst_len = '0;
        bus.data_bus  = 8'hDE;
        bus.mem_read  = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL single_start_busy: got %b, required 1", bus.busy); end
        repeat (3) @(negedge clk);
        e.data = 8'hDE; e.beat = 4'd1; e.done = 1'b1;
        sb_q.push_back(e);
        bus.data_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.data_valid, bus.done, bus.beat_cnt} !== {1'b1, 1'b1, 4'd1}) begin
            n_errors++;
            $display("FAIL single_timing: got valid=%b done=%b beat=%0d, required 1 1 1",
                     bus.data_valid, bus.done, bus.beat_cnt);
        end
        @(negedge clk);
        bus.data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.data_valid) extra_valid++;
            if (!bus.busy) busy_low++;
        end
        n_checks++;
        if (extra_valid != 0 || busy_low != 0) begin
            n_errors++;
            $display("FAIL single_hold: got extra_valid=%0d busy_low=%0d, required 0 0", extra_valid, busy_low);
        end
        n_checks++;
        if (bus.data !== 8'hDE) begin n_errors++; $display("FAIL single_hold_data: got %h, required de", bus.data); end
        end_req();
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL single_release: busy got %b, required 0", bus.busy); end
        n_checks++;
        if (sb_q.size() != 0) begin n_errors++; $display("FAIL single_pending: got %0d queued, required 0", sb_q.size()); end
    endtask

    task automatic test_burst();
        start_req(4'd3);
        pulse_ready(8'hDE, 4'd1, 1'b0);
        pulse_ready(8'hAD, 4'd2, 1'b0);
        pulse_ready(8'hBE, 4'd3, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if (sb_q.size() != 0) begin n_errors++; $display("FAIL burst_pending: got %0d queued, required 0", sb_q.size()); end
        n_checks++;
        if ({bus.busy, bus.beat_cnt, bus.data} !== {1'b1, 4'd3, 8'hBE}) begin
            n_errors++;
            $display("FAIL burst_hold: got busy=%b beat=%0d data=%h, required 1 3 be", bus.busy, bus.beat_cnt, bus.data);
        end
        end_req();
    endtask

    task automatic test_held_ready();
        sb_t e;
        int  nvalid = 0;
        int  ndone  = 0;
        start_req(4'd2);
        @(negedge clk);
        e.data = 8'h11; e.beat = 4'd1; e.done = 1'b0;
        sb_q.push_back(e);
        bus.data_bus   = 8'h11;
        bus.data_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.data_valid) nvalid++;
            if (bus.done) ndone++;
            @(negedge clk);
            bus.data_bus = 8'h99;
        end
        bus.data_ready = 1'b0;
        n_checks++;
        if (nvalid != 1 || ndone != 0) begin
            n_errors++;
            $display("FAIL held_single_capture: got valid=%0d done=%0d, required 1 0", nvalid, ndone);
        end
        pulse_ready(8'h22, 4'd2, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if (sb_q.size() != 0) begin n_errors++; $display("FAIL held_pending: got %0d queued, required 0", sb_q.size()); end
        end_req();
    endtask

    task automatic test_timeout();
        int found = 0;
        start_req(4'd1);
        @(posedge clk);
        for (int k = 1; k <= 40 && found == 0; k++) begin
            @(posedge clk); #1;
            if (bus.timeout_err) found = k;
        end
        n_checks++;
        if (found != TIMEOUT) begin
            n_errors++;
            $display("FAIL timeout_latency: got %0d cycles (0 = none in 40), required %0d", found, TIMEOUT);
        end
        n_checks++;
        if ({bus.data, bus.beat_cnt, bus.busy} !== {8'h00, 4'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL timeout_state: got data=%h beat=%0d busy=%b, required 00 0 1", bus.data, bus.beat_cnt, bus.busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin n_errors++; $display("FAIL timeout_pulse: got %b, required 0", bus.timeout_err); end
        end_req();
    endtask

    task automatic test_abort();
        start_req(4'd1);
        repeat (2) @(negedge clk);
        bus.data_bus   = 8'h5A;
        bus.data_ready = 1'b1;
        bus.mem_read   = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.data_valid, bus.busy, bus.done, bus.timeout_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL abort: got valid=%b busy=%b done=%b tmo=%b, required 0000",
                     bus.data_valid, bus.busy, bus.done, bus.timeout_err);
        end
        n_checks++;
        if (bus.data !== 8'h00) begin n_errors++; $display("FAIL abort_data: got %h, required 00", bus.data); end
        @(negedge clk);
        bus.data_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_req(4'd3);
        pulse_ready(8'hA1, 4'd1, 1'b0);
        @(negedge clk);
        reset          = 1'b1;
        bus.data_bus   = 8'hFF;
        bus.data_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.data, bus.data_valid, bus.beat_cnt, bus.busy, bus.done, bus.timeout_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: got data=%h valid=%b beat=%0d busy=%b done=%b tmo=%b, required all 0",
                     bus.data, bus.data_valid, bus.beat_cnt, bus.busy, bus.done, bus.timeout_err);
        end
        @(negedge clk);
        reset          = 1'b0;
        bus.mem_read   = 1'b0;
        bus.data_ready = 1'b0;
        start_req(4'd2);
        pulse_ready(8'h5A, 4'd1, 1'b0);
        pulse_ready(8'hC3, 4'd2, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if (sb_q.size() != 0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_recover: got %0d queued busy=%b, required 0 queued busy=1", sb_q.size(), bus.busy);
        end
        end_req();
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bus.mem_read   = 1'b0;
        bus.burst_len  = '0;
        bus.data_bus   = '0;
        bus.data_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_held_ready();
        test_timeout();
        test_abort();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
